vpipe_ex_mem_stage: RTL and testbench

VPIPE_EX_MEM_STAGE -- requirements
Module: vpipe_ex_mem_stage

---
 rtl/vpipe_pkg.sv | 39 +++
 rtl/vpipe_ex_mem_stage_if.sv | 33 +++
 rtl/vpipe_entry_reg.sv | 44 ++++
 rtl/vpipe_ex_mem_stage.sv | 162 ++++++++++++++++
 tb/tb_vpipe_ex_mem_stage.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vpipe_pkg.sv
// Shared types for the EX/MEM pipeline register: control bundle, stage state and default sizes.
package vpipe_pkg;

    localparam int VP_I = 32;
    localparam int VP_N = 8;
    localparam int VP_R = 6;

    typedef struct packed {
        logic            RegWrite;
        logic            SPWrite;
        logic            MemtoReg;
        logic            MemWrite;
        logic            FlagsWrite;
        logic [1:0]      ALUFlags;
        logic [3:0]      WA3;
        logic [3:0]      RA1;
        logic [1:0]      VSIFlag;
        logic            LDSFlag;
        logic [VP_I-1:0] Address;
    } ex_mem_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } vpipe_state_t;

    // A bubble must not write anything downstream; the remaining fields keep their value.
    function automatic ex_mem_ctrl_t kill_writes(input ex_mem_ctrl_t c);
        ex_mem_ctrl_t k;
        k            = c;
        k.RegWrite   = 1'b0;
        k.SPWrite    = 1'b0;
        k.MemWrite   = 1'b0;
        k.FlagsWrite = 1'b0;
        return k;
    endfunction

endpackage

// File: rtl/vpipe_ex_mem_stage_if.sv
// EX-side and MEM-side valid/ready bundle of the EX/MEM stage.
import vpipe_pkg::*;

interface vpipe_ex_mem_stage_if #(
    parameter int N = VP_N,
    parameter int R = VP_R
);
    logic                ValidE;
    logic                ReadyE;
    ex_mem_ctrl_t        CtrlE;
    logic [R-1:0]        LaneMaskE;
    logic [R-1:0][N-1:0] ALUOutputE;
    logic [R-1:0][N-1:0] WriteDataE;
    logic [R-1:0][N-1:0] WD1E;

    logic                ValidM;
    logic                ReadyM;
    ex_mem_ctrl_t        CtrlM;
    logic [R-1:0]        LaneMaskM;
    logic [R-1:0][N-1:0] ALUOutputM;
    logic [R-1:0][N-1:0] WriteDataM;
    logic [R-1:0][N-1:0] WD1M;

    modport master (
        output ValidE, CtrlE, LaneMaskE, ALUOutputE, WriteDataE, WD1E, ReadyM,
        input  ReadyE, ValidM, CtrlM, LaneMaskM, ALUOutputM, WriteDataM, WD1M
    );

    modport slave (
        input  ValidE, CtrlE, LaneMaskE, ALUOutputE, WriteDataE, WD1E, ReadyM,
        output ReadyE, ValidM, CtrlM, LaneMaskM, ALUOutputM, WriteDataM, WD1M
    );
endinterface

// File: rtl/vpipe_entry_reg.sv
// One held pipeline entry: load-enabled register of control, lane mask and vector payloads.
import vpipe_pkg::*;

module vpipe_entry_reg #(
    parameter int N = VP_N,
    parameter int R = VP_R
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                kill,
    input  ex_mem_ctrl_t        d_ctrl,
    input  logic [R-1:0]        d_mask,
    input  logic [R-1:0][N-1:0] d_alu,
    input  logic [R-1:0][N-1:0] d_wdata,
    input  logic [R-1:0][N-1:0] d_wd1,
    output ex_mem_ctrl_t        q_ctrl,
    output logic [R-1:0]        q_mask,
    output logic [R-1:0][N-1:0] q_alu,
    output logic [R-1:0][N-1:0] q_wdata,
    output logic [R-1:0][N-1:0] q_wd1
);

    // Load takes the new entry; kill turns the held entry into a bubble without touching payload.
    always_ff @(negedge clk) begin
        if (reset) begin
            q_ctrl  <= '0;
            q_mask  <= '0;
            q_alu   <= '0;
            q_wdata <= '0;
            q_wd1   <= '0;
        end else if (load) begin
            q_ctrl  <= d_ctrl;
            q_mask  <= d_mask;
            q_alu   <= d_alu;
            q_wdata <= d_wdata;
            q_wd1   <= d_wd1;
        end else if (kill) begin
            q_ctrl  <= kill_writes(q_ctrl);
            q_mask  <= '0;
        end
    end

endmodule

// File: rtl/vpipe_ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry (main + skid) elastic buffer, updated on negedge clk.
// Optional macro VPIPE_STALL_CNT_EN adds saturating StallCnt/FullCnt performance counters.
import vpipe_pkg::*;

module vpipe_ex_mem_stage #(
    parameter int I = VP_I,
    parameter int N = VP_N,
    parameter int R = VP_R
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    vpipe_ex_mem_stage_if.slave     bus
`ifdef VPIPE_STALL_CNT_EN
    ,
    output logic [15:0]             StallCnt,
    output logic [15:0]             FullCnt
`endif
);

    // The Address field width is fixed by the package control type.
    if (I != VP_I) begin : g_bad_addr_width
        $error("vpipe_ex_mem_stage: I must equal vpipe_pkg::VP_I");
    end

    vpipe_state_t        state_r, state_s;
    logic                valid_r, ready_r;
    logic                acc_s, out_s;
    logic                main_load_s, main_kill_s, main_from_skid_s, skid_load_s;

    ex_mem_ctrl_t        skid_ctrl, main_d_ctrl;
    logic [R-1:0]        skid_mask, main_d_mask;
    logic [R-1:0][N-1:0] skid_alu, skid_wdata, skid_wd1;
    logic [R-1:0][N-1:0] main_d_alu, main_d_wdata, main_d_wd1;

    assign acc_s = bus.ValidE & ready_r;
    assign out_s = valid_r & bus.ReadyM;

    // Next state and entry-register enables; flush overrides every other event.
    always_comb begin
        state_s          = state_r;
        main_load_s      = 1'b0;
        main_kill_s      = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
            state_s     = EMPTY;
            main_kill_s = 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (acc_s) begin
                        state_s     = ONE;
                        main_load_s = 1'b1;
                    end else begin
                        main_kill_s = 1'b1;
                    end
                end
                ONE: begin
                    if (acc_s && out_s) begin
                        main_load_s = 1'b1;
                    end else if (acc_s) begin
                        state_s     = FULL;
                        skid_load_s = 1'b1;
                    end else if (out_s) begin
                        state_s     = EMPTY;
                        main_kill_s = 1'b1;
                    end else begin
                        state_s     = ONE;
                    end
                end
                FULL: begin
                    if (out_s) begin
                        state_s          = ONE;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_s          = FULL;
                    end
                end
                default: begin
                    state_s     = EMPTY;
                    main_kill_s = 1'b1;
                end
            endcase
        end
    end

    // State plus registered ValidM/ReadyE, both decoded from the next state.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            valid_r <= (state_s != EMPTY);
            ready_r <= (state_s != FULL);
        end
    end

    assign main_d_ctrl  = main_from_skid_s ? skid_ctrl  : bus.CtrlE;
    assign main_d_mask  = main_from_skid_s ? skid_mask  : bus.LaneMaskE;
    assign main_d_alu   = main_from_skid_s ? skid_alu   : bus.ALUOutputE;
    assign main_d_wdata = main_from_skid_s ? skid_wdata : bus.WriteDataE;
    assign main_d_wd1   = main_from_skid_s ? skid_wd1   : bus.WD1E;

    vpipe_entry_reg #(.N(N), .R(R)) u_main (
        .clk     (clk),
        .reset   (reset),
        .load    (main_load_s),
        .kill    (main_kill_s),
        .d_ctrl  (main_d_ctrl),
        .d_mask  (main_d_mask),
        .d_alu   (main_d_alu),
        .d_wdata (main_d_wdata),
        .d_wd1   (main_d_wd1),
        .q_ctrl  (bus.CtrlM),
        .q_mask  (bus.LaneMaskM),
        .q_alu   (bus.ALUOutputM),
        .q_wdata (bus.WriteDataM),
        .q_wd1   (bus.WD1M)
    );

    vpipe_entry_reg #(.N(N), .R(R)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load_s),
        .kill    (1'b0),
        .d_ctrl  (bus.CtrlE),
        .d_mask  (bus.LaneMaskE),
        .d_alu   (bus.ALUOutputE),
        .d_wdata (bus.WriteDataE),
        .d_wd1   (bus.WD1E),
        .q_ctrl  (skid_ctrl),
        .q_mask  (skid_mask),
        .q_alu   (skid_alu),
        .q_wdata (skid_wdata),
        .q_wd1   (skid_wd1)
    );

    assign bus.ValidM = valid_r;
    assign bus.ReadyE = ready_r;

`ifdef VPIPE_STALL_CNT_EN
    // Saturating performance counters; only reset clears them, flush does not.
    always_ff @(negedge clk) begin
        if (reset) begin
            StallCnt <= 16'h0000;
            FullCnt  <= 16'h0000;
        end else begin
            if (valid_r && !bus.ReadyM && (StallCnt != 16'hFFFF)) begin
                StallCnt <= StallCnt + 16'h0001;
            end
            if ((state_r == FULL) && (FullCnt != 16'hFFFF)) begin
                FullCnt <= FullCnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vpipe_ex_mem_stage.sv
// Scoreboard bench for vpipe_ex_mem_stage: accepted entries are queued, popped on each MEM transfer.
import vpipe_pkg::*;

module tb_vpipe_ex_mem_stage;

    localparam int N = 8;
    localparam int R = 6;

    typedef struct packed {
        ex_mem_ctrl_t        ctrl;
        logic [R-1:0]        mask;
        logic [R-1:0][N-1:0] alu;
        logic [R-1:0][N-1:0] wd;
        logic [R-1:0][N-1:0] wd1;
    } entry_t;

    logic   clk;
    logic   reset;
    logic   flush;
    int     errors;
    int     checks;
    entry_t exp_q[$];

    vpipe_ex_mem_stage_if #(.N(N), .R(R)) bus ();

`ifdef VPIPE_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] full_cnt;
`endif

    vpipe_ex_mem_stage #(.I(32), .N(N), .R(R)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus)
`ifdef VPIPE_STALL_CNT_EN
        ,
        .StallCnt (stall_cnt),
        .FullCnt  (full_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: DUT outputs are stable at posedge; the DUT samples these inputs at the next negedge.
    always @(posedge clk) begin
        entry_t obs;
        entry_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            checks++;
            if (bus.ValidM !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL valid_vs_queue: ValidM=%b expected=%b", bus.ValidM, exp_q.size() != 0);
            end
            if (bus.ValidM !== 1'b1) begin
                checks++;
                if ({bus.CtrlM.RegWrite, bus.CtrlM.SPWrite, bus.CtrlM.MemWrite,
                     bus.CtrlM.FlagsWrite, bus.LaneMaskM} !== 10'd0) begin
                    errors++;
                    $display("FAIL bubble: we=%b%b%b%b mask=%b expected all 0", bus.CtrlM.RegWrite,
                             bus.CtrlM.SPWrite, bus.CtrlM.MemWrite, bus.CtrlM.FlagsWrite, bus.LaneMaskM);
                end
            end
            if (bus.ValidM === 1'b1 && bus.ReadyM === 1'b1 && exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                obs = '{bus.CtrlM, bus.LaneMaskM, bus.ALUOutputM, bus.WriteDataM, bus.WD1M};
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL out_entry: got=%h expected=%h", obs, e);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (bus.ValidE === 1'b1 && bus.ReadyE === 1'b1) begin
                exp_q.push_back('{bus.CtrlE, bus.LaneMaskE, bus.ALUOutputE, bus.WriteDataE, bus.WD1E});
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    function automatic entry_t rand_entry(input logic [7:0] tag);
        entry_t      e;
        logic [63:0] r;
        r      = {$urandom, $urandom};
        e.ctrl = ex_mem_ctrl_t'(r[49:0]);
        r      = {$urandom, $urandom};
        e.alu  = r[47:0];
        e.alu[0] = tag;
        r      = {$urandom, $urandom};
        e.wd   = r[47:0];
        r      = {$urandom, $urandom};
        e.wd1  = r[47:0];
        e.mask = 6'($urandom);
        return e;
    endfunction

    task automatic drive(input entry_t e, input logic v);
        bus.ValidE     = v;
        bus.CtrlE      = e.ctrl;
        bus.LaneMaskE  = e.mask;
        bus.ALUOutputE = e.alu;
        bus.WriteDataE = e.wd;
        bus.WD1E       = e.wd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.ReadyM = 1'b0;
        drive('0, 1'b0);
        nxt();
        nxt();
        checks++;
        if (bus.ValidM !== 1'b0 || bus.ReadyE !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ValidM=%b ReadyE=%b expected 0 0", bus.ValidM, bus.ReadyE);
        end
        checks++;
        if (bus.CtrlM !== '0 || bus.LaneMaskM !== '0 || bus.ALUOutputM !== '0 ||
            bus.WriteDataM !== '0 || bus.WD1M !== '0) begin
            errors++;
            $display("FAIL reset_data: ctrl=%h mask=%h alu=%h expected 0", bus.CtrlM, bus.LaneMaskM, bus.ALUOutputM);
        end
        reset = 1'b0;
        nxt();
        checks++;
        if (bus.ReadyE !== 1'b1 || bus.ValidM !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ReadyE=%b ValidM=%b expected 1 0", bus.ReadyE, bus.ValidM);
        end
    endtask

    task automatic test_single();
        entry_t e;
        e = '0;
        e.ctrl.RegWrite = 1'b1;
        e.ctrl.WA3      = 4'h3;
        e.alu[0]        = 8'h5A;
        e.mask          = 6'b111111;
        bus.ReadyM = 1'b1;
        drive(e, 1'b1);
        nxt();
        drive(e, 1'b0);
        checks++;
        if (bus.ValidM !== 1'b1 || bus.CtrlM.WA3 !== 4'h3 || bus.ALUOutputM[0] !== 8'h5A) begin
            errors++;
            $display("FAIL single_out: ValidM=%b WA3=%h lane0=%h expected 1 3 5a",
                     bus.ValidM, bus.CtrlM.WA3, bus.ALUOutputM[0]);
        end
        nxt();
        checks++;
        if (bus.ValidM !== 1'b0 || bus.CtrlM.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL single_bubble: ValidM=%b RegWrite=%b expected 0 0", bus.ValidM, bus.CtrlM.RegWrite);
        end
    endtask

    task automatic test_fill_drain();
        entry_t e[4];
        for (int k = 0; k < 4; k++) e[k] = rand_entry(8'(k + 1));
        bus.ReadyM = 1'b0;
        drive(e[0], 1'b1);
        nxt();
        checks++;
        if (bus.ValidM !== 1'b1 || bus.ReadyE !== 1'b1) begin
            errors++;
            $display("FAIL fill_one: ValidM=%b ReadyE=%b expected 1 1", bus.ValidM, bus.ReadyE);
        end
        drive(e[1], 1'b1);
        nxt();
        drive(e[2], 1'b1);
        checks++;
        if (bus.ReadyE !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: ReadyE=%b expected 0", bus.ReadyE);
        end
        nxt();
        checks++;
        if (bus.ReadyE !== 1'b0 || bus.ALUOutputM[0] !== 8'd1) begin
            errors++;
            $display("FAIL full_hold: ReadyE=%b lane0=%h expected 0 01", bus.ReadyE, bus.ALUOutputM[0]);
        end
        bus.ReadyM = 1'b1;
        nxt();
        checks++;
        if (bus.ReadyE !== 1'b1 || bus.ALUOutputM[0] !== 8'd2) begin
            errors++;
            $display("FAIL skid_exit: ReadyE=%b lane0=%h expected 1 02", bus.ReadyE, bus.ALUOutputM[0]);
        end
        nxt();
        drive(e[3], 1'b1);
        checks++;
        if (bus.ALUOutputM[0] !== 8'd3) begin
            errors++;
            $display("FAIL order3: lane0=%h expected 03", bus.ALUOutputM[0]);
        end
        nxt();
        drive(e[3], 1'b0);
        checks++;
        if (bus.ALUOutputM[0] !== 8'd4 || bus.ValidM !== 1'b1) begin
            errors++;
            $display("FAIL order4: lane0=%h ValidM=%b expected 04 1", bus.ALUOutputM[0], bus.ValidM);
        end
        nxt();
    endtask

    task automatic test_flush();
        entry_t e;
        bus.ReadyM = 1'b0;
        e = rand_entry(8'hA1);
        e.ctrl.MemWrite = 1'b1;
        drive(e, 1'b1);
        nxt();
        drive(rand_entry(8'hA2), 1'b1);
        nxt();
        drive(rand_entry(8'hA3), 1'b1);
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        drive(e, 1'b0);
        checks++;
        if (bus.ValidM !== 1'b0 || bus.CtrlM.MemWrite !== 1'b0 || bus.ReadyE !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: ValidM=%b MemWrite=%b ReadyE=%b expected 0 0 1",
                     bus.ValidM, bus.CtrlM.MemWrite, bus.ReadyE);
        end
        bus.ReadyM = 1'b1;
        repeat (3) nxt();
        // Flush while the head is leaving: the head counts as delivered, the new input is dropped.
        drive(rand_entry(8'hB1), 1'b1);
        nxt();
        drive(rand_entry(8'hB2), 1'b1);
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        drive(e, 1'b0);
        checks++;
        if (bus.ValidM !== 1'b0) begin
            errors++;
            $display("FAIL flush_out: ValidM=%b expected 0", bus.ValidM);
        end
        nxt();
    endtask

    task automatic test_lane_mask();
        entry_t e;
        e = rand_entry(8'hC1);
        e.mask = 6'b000101;
        bus.ReadyM = 1'b1;
        drive(e, 1'b1);
        nxt();
        drive(e, 1'b0);
        checks++;
        if (bus.ValidM !== 1'b1 || bus.LaneMaskM !== 6'b000101 || bus.WD1M !== e.wd1) begin
            errors++;
            $display("FAIL lane_mask: ValidM=%b mask=%b wd1=%h expected 1 000101 %h",
                     bus.ValidM, bus.LaneMaskM, bus.WD1M, e.wd1);
        end
        nxt();
        checks++;
        if (bus.LaneMaskM !== 6'b000000) begin
            errors++;
            $display("FAIL lane_mask_idle: mask=%b expected 000000", bus.LaneMaskM);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        bus.ReadyM = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(rand_entry(8'(k)), 1'b1);
            nxt();
            checks++;
            if (bus.ValidM !== 1'b1 || bus.ReadyE !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: ValidM=%b ReadyE=%b expected 1 1", k, bus.ValidM, bus.ReadyE);
            end
        end
        drive(rand_entry(8'h00), 1'b0);
        for (int k = 0; k < 400; k++) begin
            bus.ReadyM = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            acc        = bus.ValidE && bus.ReadyE;
            if (acc || !bus.ValidE) drive(rand_entry(8'(k)), $urandom_range(0, 2) != 0);
            nxt();
        end
        flush = 1'b0;
        bus.ReadyM = 1'b1;
        drive(rand_entry(8'h00), 1'b0);
        repeat (4) nxt();
        checks++;
        if (bus.ValidM !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: ValidM=%b queued=%0d expected 0 0", bus.ValidM, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.ReadyM = 1'b0;
        drive(rand_entry(8'hD1), 1'b1);
        nxt();
        drive(rand_entry(8'hD2), 1'b1);
        nxt();
        drive(rand_entry(8'hD3), 1'b1);
        reset = 1'b1;
        flush = 1'b1;
        nxt();
        checks++;
        if (bus.ValidM !== 1'b0 || bus.ReadyE !== 1'b0 || bus.CtrlM !== '0 || bus.ALUOutputM !== '0) begin
            errors++;
            $display("FAIL reset_mid: ValidM=%b ReadyE=%b ctrl=%h alu=%h expected 0 0 0 0",
                     bus.ValidM, bus.ReadyE, bus.CtrlM, bus.ALUOutputM);
        end
        reset = 1'b0;
        flush = 1'b0;
        drive('0, 1'b0);
        nxt();
        checks++;
        if (bus.ReadyE !== 1'b1 || bus.ValidM !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: ReadyE=%b ValidM=%b expected 1 0", bus.ReadyE, bus.ValidM);
        end
    endtask

`ifdef VPIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        bus.ReadyM = 1'b0;
        drive(rand_entry(8'hE1), 1'b1);
        nxt();
        drive('0, 1'b0);
        repeat (70000) nxt();
        checks++;
        if (stall_cnt !== 16'hFFFF || full_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL stall_sat: StallCnt=%h FullCnt=%h expected ffff 0000", stall_cnt, full_cnt);
        end
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        checks++;
        if (stall_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL stall_reset: StallCnt=%h expected 0000", stall_cnt);
        end
        nxt();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_fill_drain();
        test_flush();
        test_lane_mask();
        test_back_to_back();
        test_reset_mid();
`ifdef VPIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
